// File: rtl/ieee754_pkg.sv
// Shared IEEE 754 single-precision definitions for the adder and the float-to-int converter.
// Field widths, integer limits, operand class encoding and common constants for benches.
package ieee754_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int BIAS   = 127;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {CLS_ZERO, CLS_FINITE, CLS_INF, CLS_NAN} fp_class_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             sticky;  // nonzero fraction dropped from a denormal
    fp_class_e        cls;
  } fp_unpacked_t;

  localparam logic [31:0] CS_ZERO     = 32'h0000_0000;
  localparam logic [31:0] CS_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] CS_HALF     = 32'h3F00_0000;
  localparam logic [31:0] CS_ONE      = 32'h3F80_0000;
  localparam logic [31:0] CS_TWO      = 32'h4000_0000;
  localparam logic [31:0] CS_THREE    = 32'h4040_0000;
  localparam logic [31:0] CS_FOUR     = 32'h4080_0000;
  localparam logic [31:0] CS_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] CS_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] CS_QNAN     = 32'h7FC0_0000;
endpackage

// File: rtl/ieee_unpack.sv
// Combinational split of a single-precision word into sign, exponent, significand and class.
// Denormals contribute no significand; their nonzero fraction is reported through sticky.
import ieee754_pkg::*;

module ieee_unpack (
  input  logic [31:0]  word_i,
  output fp_unpacked_t unp_o
);
  logic [EXP_W-1:0]  exp;
  logic [FRAC_W-1:0] frac;

  always_comb begin
    exp          = word_i[30:23];
    frac         = word_i[22:0];
    unp_o.sign   = word_i[31];
    unp_o.exp    = exp;
    unp_o.sig    = (exp != '0) ? {1'b1, frac} : '0;
    unp_o.sticky = (exp == '0) && (frac != '0);
    if (exp == '1)
      unp_o.cls = (frac != '0) ? CLS_NAN : CLS_INF;
    else if ((exp == '0) && (frac == '0))
      unp_o.cls = CLS_ZERO;
    else
      unp_o.cls = CLS_FINITE;
  end
endmodule

// File: rtl/ieee_to_int.sv
// Pipelined single-precision float to signed 32-bit integer converter.
// Input register, then unpack, align and round/saturate stages; enable_in freezes the whole pipe.
import ieee754_pkg::*;

module ieee_to_int #(
  parameter bit ROUND_NEAREST = 1'b1,
  parameter bit RESET_OUTPUTS = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic        valid_in,
  input  logic [31:0] inputA,
  output logic        valid_out,
  output logic [31:0] outputC,
  output logic        invalid_out,
  output logic        inexact_out
);
  localparam int STAGES = 4;
  localparam logic [EXP_W-1:0] E_OVF  = EXP_W'(BIAS + 31);
  localparam logic [EXP_W-1:0] E_INT0 = EXP_W'(BIAS + FRAC_W);
  localparam logic [EXP_W-1:0] E_HALF = EXP_W'(BIAS - 1);

  logic [STAGES:1] vld_pipe_q;

  logic [31:0]  in_q;
  fp_unpacked_t unp_d, s1_q;

  logic         s2_sign_q;
  fp_class_e    s2_cls_q;
  logic [32:0]  s2_mag_q, s2_mag_d;
  logic         s2_guard_q, s2_guard_d, s2_sticky_q, s2_sticky_d;
  logic [47:0]  ext;

  logic [32:0]  mag_r;
  logic         inc;
  logic [31:0]  out_q, out_d;
  logic         inv_q, inv_d, inx_q, inx_d;

  ieee_unpack u_unpack (.word_i(in_q), .unp_o(unp_d));

  // Align: value = sig * 2^(exp-150); magnitudes >= 2^31 collapse to 2^31 (exact) or 2^32 (too big).
  always_comb begin
    s2_mag_d    = '0;
    s2_guard_d  = 1'b0;
    s2_sticky_d = s1_q.sticky;
    ext         = '0;
    if (s1_q.exp >= E_OVF) begin
      s2_mag_d = ((s1_q.exp == E_OVF) && (s1_q.sig == {1'b1, {FRAC_W{1'b0}}}))
                 ? 33'h0_8000_0000 : 33'h1_0000_0000;
    end else if (s1_q.exp >= E_INT0) begin
      s2_mag_d = 33'(s1_q.sig) << (s1_q.exp - E_INT0);
    end else if (s1_q.exp >= E_HALF) begin
      ext         = {s1_q.sig, 24'b0} >> (E_INT0 - s1_q.exp);
      s2_mag_d    = 33'(ext[47:24]);
      s2_guard_d  = ext[23];
      s2_sticky_d = |ext[22:0];
    end else begin
      s2_sticky_d = s1_q.sticky | (s1_q.sig != '0);
    end
  end

  // Round, then saturate on the 33-bit magnitude so a rounding carry cannot wrap.
  always_comb begin
    inc   = ROUND_NEAREST && s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
    mag_r = s2_mag_q + 33'(inc);
    out_d = '0;
    inv_d = 1'b0;
    inx_d = 1'b0;
    case (s2_cls_q)
      CLS_NAN: begin
        out_d = INT_MIN;
        inv_d = 1'b1;
      end
      CLS_INF: begin
        out_d = s2_sign_q ? INT_MIN : INT_MAX;
        inv_d = 1'b1;
      end
      CLS_ZERO: out_d = '0;
      default: begin
        if (!s2_sign_q && (mag_r > {1'b0, INT_MAX})) begin
          out_d = INT_MAX;
          inv_d = 1'b1;
        end else if (s2_sign_q && (mag_r > {1'b0, INT_MIN})) begin
          out_d = INT_MIN;
          inv_d = 1'b1;
        end else begin
          out_d = s2_sign_q ? (~mag_r[31:0] + 32'd1) : mag_r[31:0];
          inx_d = s2_guard_q | s2_sticky_q;
        end
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in)
      vld_pipe_q <= '0;
    else if (enable_in)
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], valid_in};
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      if (RESET_OUTPUTS) begin
        out_q <= '0;
        inv_q <= 1'b0;
        inx_q <= 1'b0;
      end
    end else if (enable_in) begin
      if (valid_in)      in_q <= inputA;
      if (vld_pipe_q[1]) s1_q <= unp_d;
      if (vld_pipe_q[2]) begin
        s2_sign_q   <= s1_q.sign;
        s2_cls_q    <= s1_q.cls;
        s2_mag_q    <= s2_mag_d;
        s2_guard_q  <= s2_guard_d;
        s2_sticky_q <= s2_sticky_d;
      end
      if (vld_pipe_q[3]) begin
        out_q <= out_d;
        inv_q <= inv_d;
        inx_q <= inx_d;
      end
    end
  end

  assign valid_out   = vld_pipe_q[STAGES];
  assign outputC     = out_q;
  assign invalid_out = inv_q;
  assign inexact_out = inx_q;
endmodule
